face_coord_uart_tx: RTL

//  Return path to the laptop. Queues each detection result from the Viola-Jones pipeline
//  (face_coords plus pyramid_number, one per face_coords_ready pulse) in a small FIFO.

---
 rtl/face_coord_uart_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/face_coord_uart_tx.sv
// face_coord_uart_tx: queues Viola-Jones detections and sends each one as a fixed UART 8N1 packet.
// Define FACE_TX_CHECKSUM_EN to append an XOR checksum byte to every packet.
module face_coord_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [1:0][31:0]                 face_coords,
  input  logic                             face_coords_ready,
  input  logic [3:0]                       pyramid_number,
  output logic                             serial_tx,
  output logic                             tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int ENTRY_W = 36;
`ifdef FACE_TX_CHECKSUM_EN
  localparam int NUM_BYTES = 7;
`else
  localparam int NUM_BYTES = 6;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q;
  logic                 fifo_empty, fifo_full, pop;
  logic                 vld_p0;
  logic [ENTRY_W-1:0]   entry_p0;
  logic [ENTRY_W-1:0]   pkt_p1;
  logic [7:0]           shift_p2;
  logic [7:0]           cur_byte;
  logic [BAUD_W-1:0]    baud_q;
  logic [2:0]           bit_q, byte_q;
  logic                 baud_done, last_bit, last_byte;
  logic                 tx_bit, serial_tx_q;
  logic                 unused_coord_hi;

  // Only the low 16 bits of each coordinate travel in the packet.
  assign unused_coord_hi = ^{face_coords[0][31:16], face_coords[1][31:16]};

  // Stage p0: pack the detection and push it into the FIFO.
  assign entry_p0   = {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign vld_p0     = face_coords_ready && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({vld_p0, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (face_coords_ready && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (vld_p0) fifo_mem[wr_ptr] <= entry_p0;
  end

  // Stage p1: popped packet, selected byte by byte.
`ifdef FACE_TX_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = 8'hFA ^ {4'h0, pkt_p1[35:32]} ^ pkt_p1[31:24] ^ pkt_p1[23:16]
                  ^ pkt_p1[15:8] ^ pkt_p1[7:0];
`endif

  always_comb begin
    cur_byte = 8'hFA;
    case (byte_q)
      3'd0:    cur_byte = 8'hFA;
      3'd1:    cur_byte = {4'h0, pkt_p1[35:32]};
      3'd2:    cur_byte = pkt_p1[31:24];
      3'd3:    cur_byte = pkt_p1[23:16];
      3'd4:    cur_byte = pkt_p1[15:8];
      3'd5:    cur_byte = pkt_p1[7:0];
`ifdef FACE_TX_CHECKSUM_EN
      3'd6:    cur_byte = checksum;
`endif
      default: cur_byte = 8'hFA;
    endcase
  end

  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_q == 3'd7);
  assign last_byte = (byte_q == 3'(NUM_BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (baud_done) state_d = S_DATA;
      S_DATA:  if (baud_done && last_bit) state_d = S_STOP;
      S_STOP:  if (baud_done) state_d = last_byte ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    pop    = 1'b0;
    case (state_q)
      S_IDLE:  pop    = !fifo_empty;
      S_START: tx_bit = 1'b0;
      S_DATA:  tx_bit = shift_p2[0];
      S_STOP:  tx_bit = 1'b1;
      default: tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      serial_tx_q <= 1'b1;
    end else begin
      serial_tx_q <= tx_bit;
      if (state_q == S_IDLE || baud_done) baud_q <= '0;
      else                                baud_q <= baud_q + BAUD_W'(1);
      if (state_q != S_DATA) bit_q <= '0;
      else if (baud_done)    bit_q <= bit_q + 3'd1;
      if (pop)
        byte_q <= '0;
      else if (state_q == S_STOP && baud_done && !last_byte)
        byte_q <= byte_q + 3'd1;
    end
  end

  // Stage p2: packet register loads on pop; shifter loads as each start bit ends.
  always_ff @(posedge clock) begin
    if (pop) pkt_p1 <= fifo_mem[rd_ptr];
    if (state_q == S_START && baud_done)
      shift_p2 <= cur_byte;
    else if (state_q == S_DATA && baud_done)
      shift_p2 <= {1'b0, shift_p2[7:1]};
  end

  // The line is registered, so it trails the FSM by one cycle with unchanged bit widths.
  assign serial_tx  = serial_tx_q;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
